// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 bus responder: cycle kinds, FSM states, constants.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package z80_bus_pkg;

  // Kind of CPU bus cycle decoded from the control pins
  typedef enum logic [2:0] {
    CYC_NONE  = 3'd0,
    CYC_FETCH = 3'd1,
    CYC_MRD   = 3'd2,
    CYC_MWR   = 3'd3,
    CYC_IORD  = 3'd4,
    CYC_IOWR  = 3'd5,
    CYC_INTA  = 3'd6,
    CYC_RFSH  = 3'd7
  } cyc_t;

  // Responder FSM states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_BE_WAIT  = 3'd1,
    ST_DRIVE    = 3'd2,
    ST_INTA_DRV = 3'd3,
    ST_HOLD     = 3'd4
  } state_t;

  localparam logic [7:0] DEFAULT_INT_VECTOR = 8'hFF;
  localparam int         WCNT_W             = 8;

  // True for cycles addressed to I/O space
  function automatic logic cyc_is_io(input cyc_t c);
    return (c == CYC_IORD) || (c == CYC_IOWR);
  endfunction

  // True for cycles that write to the back end
  function automatic logic cyc_is_wr(input cyc_t c);
    return (c == CYC_MWR) || (c == CYC_IOWR);
  endfunction

endpackage

// File: rtl/z80_wait_gen.sv
// Loadable down-counter that sets the minimum number of WAIT clocks in a cycle.
// Latency: expired is combinational from the count; load/decrement take effect next clock.
// Backpressure: none; decrement saturates at zero.
module z80_wait_gen
  import z80_bus_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WCNT_W-1:0] load_val,
  input  logic              dec,
  output logic              expired
);

  logic [WCNT_W-1:0] cnt;

  // Load at decode, then count down once per clock while the cycle waits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - WCNT_W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/z80_bus_responder.sv
// Slave end of the Z80 bus: decodes CPU strobes, forwards one back-end request per cycle, drives read data / INTA vector.
// Latency: be_req one clock after decode; nWAIT released the clock after ack and the minimum wait both finish.
// Backpressure: the CPU is stretched with nWAIT until be_ack; be_req is held level until acked.
module z80_bus_responder
  import z80_bus_pkg::*;
#(
  parameter int         WAIT_MEM   = 0,
  parameter int         WAIT_IO    = 0,
  parameter logic [7:0] INT_VECTOR = DEFAULT_INT_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nM1,
  input  logic        nMREQ,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  input  logic        nRFSH,
  input  logic [15:0] A,
  input  logic [7:0]  D_in,
  output logic [7:0]  D_out,
  output logic        D_oe,
  output logic        nWAIT,
  output logic        nINT,
  input  logic        irq_in,
  output logic        be_req,
  output logic        be_we,
  output logic        be_io,
  output logic [15:0] be_addr,
  output logic [7:0]  be_wdata,
  input  logic        be_ack,
  input  logic [7:0]  be_rdata,
  output logic [2:0]  cyc_type,
  output logic        cyc_done
);

  localparam logic [WCNT_W-1:0] WAIT_MEM_CNT = WCNT_W'(WAIT_MEM);
  localparam logic [WCNT_W-1:0] WAIT_IO_CNT  = WCNT_W'(WAIT_IO);

  state_t state, state_nxt;
  cyc_t   dec_cyc;
  logic   start_be, start_inta, ack_seen, wait_expired;
  logic   irq_q, irq_pending, irq_rise;

  // Priority decode of the active-low strobes into a cycle kind
  always_comb begin
    dec_cyc = CYC_NONE;
    if (!nM1 && !nIORQ)        dec_cyc = CYC_INTA;
    else if (!nMREQ && !nRFSH) dec_cyc = CYC_RFSH;
    else if (!nMREQ && !nRD)   dec_cyc = nM1 ? CYC_MRD : CYC_FETCH;
    else if (!nMREQ && !nWR)   dec_cyc = CYC_MWR;
    else if (!nIORQ && !nRD)   dec_cyc = CYC_IORD;
    else if (!nIORQ && !nWR)   dec_cyc = CYC_IOWR;
  end

  // Next-state logic and data-bus enable
  always_comb begin
    state_nxt = state;
    D_oe      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dec_cyc == CYC_INTA)      state_nxt = ST_INTA_DRV;
        else if (dec_cyc == CYC_RFSH) state_nxt = ST_HOLD;
        else if (dec_cyc != CYC_NONE) state_nxt = ST_BE_WAIT;
      end
      ST_BE_WAIT: begin
        // A read whose strobe already went away (CPU reset) skips driving the bus
        if ((be_ack || ack_seen) && wait_expired)
          state_nxt = (!be_we && !nRD) ? ST_DRIVE : ST_HOLD;
      end
      ST_DRIVE: begin
        D_oe = !nRD;
        if (nRD) state_nxt = ST_HOLD;
      end
      ST_INTA_DRV: begin
        D_oe = 1'b1;
        if (nIORQ) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (nMREQ && nIORQ) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign start_be   = (state == ST_IDLE) && (state_nxt == ST_BE_WAIT);
  assign start_inta = (state == ST_IDLE) && (dec_cyc == CYC_INTA);
  assign irq_rise   = irq_in && !irq_q;
  assign nINT       = !irq_pending;

  z80_wait_gen u_wait_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (start_be),
    .load_val (cyc_is_io(dec_cyc) ? WAIT_IO_CNT : WAIT_MEM_CNT),
    .dec      (state == ST_BE_WAIT),
    .expired  (wait_expired)
  );

  // State register, back-end request, WAIT and data registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      nWAIT    <= 1'b1;
      D_out    <= 8'h00;
      be_req   <= 1'b0;
      be_we    <= 1'b0;
      be_io    <= 1'b0;
      be_addr  <= 16'h0000;
      be_wdata <= 8'h00;
      ack_seen <= 1'b0;
      cyc_type <= CYC_NONE;
      cyc_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      nWAIT    <= (state_nxt != ST_BE_WAIT);
      cyc_done <= (state_nxt == ST_HOLD) && (state != ST_HOLD);
      if ((state == ST_IDLE) && (dec_cyc != CYC_NONE)) cyc_type <= dec_cyc;
      if (start_inta) D_out <= INT_VECTOR;
      if (start_be) begin
        be_req   <= 1'b1;
        be_we    <= cyc_is_wr(dec_cyc);
        be_io    <= cyc_is_io(dec_cyc);
        be_addr  <= A;
        be_wdata <= D_in;
        ack_seen <= 1'b0;
      end else if ((state == ST_BE_WAIT) && be_ack) begin
        be_req   <= 1'b0;
        ack_seen <= 1'b1;
        if (!be_we) D_out <= be_rdata;
      end
    end
  end

  // Interrupt request: registered edge detect, cleared by acknowledge, set wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q       <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      irq_q <= irq_in;
      if (irq_rise)        irq_pending <= 1'b1;
      else if (start_inta) irq_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder with a request scoreboard.
// Latency: n/a.
// Backpressure: bench plays the back end, acking after a programmable delay.
module tb_z80_bus_responder;
  import z80_bus_pkg::*;

  typedef struct packed {
    logic        we;
    logic        io;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        nM1, nMREQ, nIORQ, nRD, nWR, nRFSH;
  logic [15:0] A;
  logic [7:0]  D_in, D_out, be_rdata, be_wdata;
  logic        D_oe, nWAIT, nINT, irq_in, be_req, be_we, be_io, be_ack, cyc_done;
  logic [15:0] be_addr;
  logic [2:0]  cyc_type;

  int n_assert = 0;
  int n_fail   = 0;

  req_t       exp_q[$];
  logic [7:0] rd_q[$];

  always #5 clk = ~clk;

  z80_bus_responder #(.WAIT_MEM(2), .WAIT_IO(1), .INT_VECTOR(8'hFF)) dut (
    .clk(clk), .reset(reset), .nM1(nM1), .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD),
    .nWR(nWR), .nRFSH(nRFSH), .A(A), .D_in(D_in), .D_out(D_out), .D_oe(D_oe),
    .nWAIT(nWAIT), .nINT(nINT), .irq_in(irq_in), .be_req(be_req), .be_we(be_we),
    .be_io(be_io), .be_addr(be_addr), .be_wdata(be_wdata), .be_ack(be_ack),
    .be_rdata(be_rdata), .cyc_type(cyc_type), .cyc_done(cyc_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic release_bus();
    nM1 = 1'b1; nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nRFSH = 1'b1;
  endtask

  // One CPU cycle against the DUT, with the bench acting as back end
  task automatic bus_cycle(input logic io, input logic wr, input logic m1,
                           input logic [15:0] addr, input logic [7:0] wd,
                           input int ack_delay, input logic [7:0] rd,
                           output int wlow, output int reqs, output int done, output int oe);
    req_t       e;
    logic [7:0] r;
    logic       acked, prev_req, fin;
    int         age;
    wlow = 0; reqs = 0; done = 0; oe = 0;
    acked = 1'b0; prev_req = 1'b0; fin = 1'b0; age = 0;
    e.we = wr; e.io = io; e.addr = addr; e.wdata = wd;
    exp_q.push_back(e);
    if (!wr) rd_q.push_back(rd);
    A = addr; D_in = wd;
    nM1 = !m1; nMREQ = io; nIORQ = !io; nRD = wr; nWR = !wr;
    for (int k = 0; k < 40 && !fin; k++) begin
      @(negedge clk);
      be_ack = 1'b0;
      if (!nWAIT)  wlow++;
      if (cyc_done) done++;
      if (D_oe)    oe++;
      if (be_req && !prev_req) begin
        reqs++;
        check("req_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("be_we",    32'(be_we),    32'(e.we));
          check("be_io",    32'(be_io),    32'(e.io));
          check("be_addr",  32'(be_addr),  32'(e.addr));
          check("be_wdata", 32'(be_wdata), 32'(e.wdata));
        end
      end
      prev_req = be_req;
      if (be_req && !acked) begin
        if (age == ack_delay) begin
          be_ack = 1'b1; be_rdata = rd; acked = 1'b1;
        end else begin
          age++;
        end
      end
      if (acked && nWAIT && !be_req) fin = 1'b1;
    end
    check("cycle_completes", 32'(fin), 32'd1);
    if (!wr && fin) begin
      r = rd_q.pop_front();
      check("d_oe_read", 32'(D_oe), 32'd1);
      check("d_out_read", 32'(D_out), 32'(r));
    end
    release_bus();
    repeat (3) begin
      @(negedge clk);
      if (cyc_done) done++;
      if (D_oe) oe++;
      if (be_req && !prev_req) reqs++;
      prev_req = be_req;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

  initial begin
    int wlow, reqs, done, oe;
    reset = 1'b0; release_bus(); A = '0; D_in = '0;
    be_ack = 1'b0; be_rdata = '0; irq_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_nwait",    32'(nWAIT),    32'd1);
    check("rst_nint",     32'(nINT),     32'd1);
    check("rst_d_oe",     32'(D_oe),     32'd0);
    check("rst_be_req",   32'(be_req),   32'd0);
    check("rst_cyc_type", 32'(cyc_type), 32'(CYC_NONE));
    check("rst_cyc_done", 32'(cyc_done), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Memory read with two minimum WAIT clocks, ack one clock after req
    bus_cycle(1'b0, 1'b0, 1'b0, 16'h1234, 8'h00, 1, 8'hA5, wlow, reqs, done, oe);
    check("mrd_wait_ge3", 32'(wlow >= 3), 32'd1);
    check("mrd_reqs",     32'(reqs), 32'd1);
    check("mrd_done",     32'(done), 32'd1);
    check("mrd_type",     32'(cyc_type), 32'(CYC_MRD));

    // Memory write: never drives the data bus
    bus_cycle(1'b0, 1'b1, 1'b0, 16'h8000, 8'h3C, 0, 8'h00, wlow, reqs, done, oe);
    check("mwr_reqs", 32'(reqs), 32'd1);
    check("mwr_done", 32'(done), 32'd1);
    check("mwr_oe",   32'(oe),   32'd0);
    check("mwr_type", 32'(cyc_type), 32'(CYC_MWR));

    // Opcode fetch followed by refresh
    bus_cycle(1'b0, 1'b0, 1'b1, 16'h0100, 8'h00, 0, 8'h5A, wlow, reqs, done, oe);
    check("fetch_reqs", 32'(reqs), 32'd1);
    check("fetch_type", 32'(cyc_type), 32'(CYC_FETCH));
    nMREQ = 1'b0; nRFSH = 1'b0; A = 16'h0042;
    wlow = 0; reqs = 0; done = 0;
    repeat (4) begin
      @(negedge clk);
      if (!nWAIT) wlow++;
      if (be_req) reqs++;
      if (cyc_done) done++;
    end
    check("rfsh_type",  32'(cyc_type), 32'(CYC_RFSH));
    check("rfsh_wait",  32'(wlow), 32'd0);
    check("rfsh_reqs",  32'(reqs), 32'd0);
    check("rfsh_done",  32'(done), 32'd1);
    release_bus();
    repeat (2) @(negedge clk);

    // I/O read, one minimum WAIT clock, ack in the same clock as req
    bus_cycle(1'b1, 1'b0, 1'b0, 16'h00FE, 8'h00, 0, 8'h77, wlow, reqs, done, oe);
    check("iord_wait", 32'(wlow), 32'd2);
    check("iord_reqs", 32'(reqs), 32'd1);
    check("iord_type", 32'(cyc_type), 32'(CYC_IORD));

    // I/O write
    bus_cycle(1'b1, 1'b1, 1'b0, 16'h0010, 8'h99, 2, 8'h00, wlow, reqs, done, oe);
    check("iowr_wait", 32'(wlow), 32'd3);
    check("iowr_oe",   32'(oe),   32'd0);

    // Interrupt request and acknowledge
    irq_in = 1'b1;
    @(negedge clk);
    check("irq_nint_low", 32'(nINT), 32'd0);
    irq_in = 1'b0;
    @(negedge clk);
    nM1 = 1'b0; nIORQ = 1'b0;
    @(negedge clk);
    check("inta_d_oe",  32'(D_oe),   32'd1);
    check("inta_d_out", 32'(D_out),  32'hFF);
    check("inta_nint",  32'(nINT),   32'd1);
    check("inta_req",   32'(be_req), 32'd0);
    check("inta_type",  32'(cyc_type), 32'(CYC_INTA));
    release_bus();
    repeat (3) @(negedge clk);
    check("inta_d_oe_off", 32'(D_oe), 32'd0);

    // Edge coinciding with the acknowledge keeps the request pending
    irq_in = 1'b1; nM1 = 1'b0; nIORQ = 1'b0;
    @(negedge clk);
    check("inta_set_wins", 32'(nINT), 32'd0);
    release_bus(); irq_in = 1'b0;
    repeat (3) @(negedge clk);
    check("inta_set_holds", 32'(nINT), 32'd0);

    // Reset in the middle of a back-end request
    A = 16'h4321; nMREQ = 1'b0; nRD = 1'b0;
    @(negedge clk);
    check("mid_req_up", 32'(be_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_be_req",   32'(be_req),   32'd0);
    check("arst_nwait",    32'(nWAIT),    32'd1);
    check("arst_be_addr",  32'(be_addr),  32'd0);
    check("arst_d_out",    32'(D_out),    32'd0);
    check("arst_nint",     32'(nINT),     32'd1);
    check("arst_cyc_type", 32'(cyc_type), 32'(CYC_NONE));
    release_bus();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus_cycle(1'b0, 1'b0, 1'b0, 16'h0042, 8'h00, 0, 8'hC3, wlow, reqs, done, oe);
    check("post_rst_reqs", 32'(reqs), 32'd1);
    check("post_rst_done", 32'(done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
